floating_point_multiplier_iter: RTL and testbench

//  Iterative IEEE-754-style FP multiplier; the inverse operation of the pipelined divider in the arithmetic library.
//  One shift-add step per cycle over the (1+FRAC_WIDTH)-bit significand, with a valid/ready handshake on both sides.

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_operand_unpack.sv | 29 ++
 rtl/floating_point_multiplier_iter.sv | 147 ++++++++++++++
 tb/tb_floating_point_multiplier_iter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and exponent helpers for the floating-point arithmetic library.
package fp_pkg;

   typedef enum logic [1:0] {
      FP_ZERO,
      FP_NORMAL,
      FP_INF,
      FP_NAN
   } fp_class_t;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      NORM,
      DONE
   } fp_mul_state_t;

   function automatic int fp_bias(input int exp_width);
      return (1 << (exp_width - 1)) - 1;
   endfunction

   function automatic int fp_exp_max(input int exp_width);
      return (1 << exp_width) - 1;
   endfunction

endpackage

// File: rtl/fp_operand_unpack.sv
// Splits a {sign,exp,frac} operand into sign, exponent, significand with hidden
// bit, and its class. Exponent zero is treated as zero regardless of fraction.
module fp_operand_unpack
   import fp_pkg::*;
#(
   parameter int EXP_WIDTH  = 8,
   parameter int FRAC_WIDTH = 23
) (
   input  logic [EXP_WIDTH+FRAC_WIDTH:0] fp,
   output logic                          sign,
   output logic [EXP_WIDTH-1:0]          exp_bits,
   output logic [FRAC_WIDTH:0]           sig,
   output fp_class_t                     cls
);

   // Field split and classification.
   always_comb begin
      sign     = fp[EXP_WIDTH+FRAC_WIDTH];
      exp_bits = fp[EXP_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
      sig      = {(exp_bits != '0), fp[FRAC_WIDTH-1:0]};
      if (exp_bits == '0)
         cls = FP_ZERO;
      else if (&exp_bits)
         cls = (fp[FRAC_WIDTH-1:0] == '0) ? FP_INF : FP_NAN;
      else
         cls = FP_NORMAL;
   end

endmodule

// File: rtl/floating_point_multiplier_iter.sv
// Iterative shift-add floating-point multiplier, one operation in flight.
// Subnormal operands and results flush to zero; rounding is nearest, ties away,
// using only the guard bit.
// Optional build macro FP_MUL_ITER_EARLY_OUT_EN: special-class operands bypass
// the multiply loop and go straight to NORM.
module floating_point_multiplier_iter
   import fp_pkg::*;
#(
   parameter int EXP_WIDTH  = 8,
   parameter int FRAC_WIDTH = 23
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [EXP_WIDTH+FRAC_WIDTH:0] fp_a_i,
   input  logic [EXP_WIDTH+FRAC_WIDTH:0] fp_b_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   output logic [EXP_WIDTH+FRAC_WIDTH:0] fp_o,
   output logic                          valid_o,
   input  logic                          ready_i
);

   localparam int P     = FRAC_WIDTH + 1;
   localparam int W     = 1 + EXP_WIDTH + FRAC_WIDTH;
   localparam int EW2   = EXP_WIDTH + 2;
   localparam int CNT_W = $clog2(P);
   localparam logic signed [EW2-1:0] BIAS_S    = EW2'(fp_bias(EXP_WIDTH));
   localparam logic signed [EW2-1:0] EXP_MAX_S = EW2'(fp_exp_max(EXP_WIDTH));
   localparam logic signed [EW2-1:0] ZERO_S    = '0;
   localparam logic signed [EW2-1:0] ONE_S     = EW2'(1);

   fp_mul_state_t           state_q, state_d;
   logic [CNT_W-1:0]        step_q;
   logic                    sign_a, sign_b, sign_q;
   logic [EXP_WIDTH-1:0]    exp_a, exp_b;
   logic [P-1:0]            sig_a, sig_b;
   fp_class_t               cls_a, cls_b, cls_a_q, cls_b_q;
   logic signed [EW2-1:0]   exp_sum_q, e_adj;
   logic [P-1:0]            mcand_q, mplier_q;
   logic [2*P-1:0]          acc_q;
   logic [P:0]              add_sum;
   logic [W-1:0]            fp_q, result_d;
   logic                    accept, norm_hi, guard, nan_res, inf_res, zero_res;
   logic [P-1:0]            sig_n, sig_r;
   logic [P:0]              rnd;

   // Nearest rounding, ties away from zero, guard bit only.
   function automatic logic [P:0] round_nearest(input logic [P-1:0] sig, input logic g);
      return {1'b0, sig} + {{P{1'b0}}, g};
   endfunction

   // Exponent range saturation: overflow to infinity, underflow (or a product
   // without a hidden bit) flushes to signed zero.
   function automatic logic [W-1:0] pack_result(input logic s, input logic signed [EW2-1:0] e,
                                                input logic [P-1:0] sig);
      if (!sig[P-1] || e <= ZERO_S)
         return {s, {(W-1){1'b0}}};
      else if (e >= EXP_MAX_S)
         return {s, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
      return {s, e[EXP_WIDTH-1:0], sig[FRAC_WIDTH-1:0]};
   endfunction

   fp_operand_unpack #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_unpack_a (
      .fp(fp_a_i), .sign(sign_a), .exp_bits(exp_a), .sig(sig_a), .cls(cls_a)
   );

   fp_operand_unpack #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_unpack_b (
      .fp(fp_b_i), .sign(sign_b), .exp_bits(exp_b), .sig(sig_b), .cls(cls_b)
   );

   assign accept  = valid_i && (state_q == IDLE);
   assign ready_o = (state_q == IDLE);
   assign valid_o = (state_q == DONE);
   assign fp_o    = fp_q;
   assign add_sum = {1'b0, acc_q[2*P-1:P]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) begin
`ifdef FP_MUL_ITER_EARLY_OUT_EN
            state_d = (cls_a != FP_NORMAL || cls_b != FP_NORMAL) ? NORM : MUL;
`else
            state_d = MUL;
`endif
         end
         MUL:  if (step_q == CNT_W'(P - 1)) state_d = NORM;
         NORM: state_d = DONE;
         DONE: if (ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control state, step counter and result register; reset drops any in-flight op.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         step_q  <= '0;
         fp_q    <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= (state_q == MUL) ? step_q + CNT_W'(1) : '0;
         if (state_q == NORM) fp_q <= result_d;
      end
   end

   // Operand capture and one shift-add step per MUL cycle.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         sign_q    <= sign_a ^ sign_b;
         cls_a_q   <= cls_a;
         cls_b_q   <= cls_b;
         exp_sum_q <= $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;
         mcand_q   <= sig_a;
         mplier_q  <= sig_b;
         acc_q     <= '0;
      end else if (state_q == MUL) begin
         acc_q    <= (2*P)'({add_sum, acc_q[P-1:0]} >> 1);
         mplier_q <= mplier_q >> 1;
      end
   end

   // Normalise, round and special-case substitution for the NORM cycle.
   always_comb begin
      norm_hi  = acc_q[2*P-1];
      sig_n    = norm_hi ? acc_q[2*P-1:P] : acc_q[2*P-2:P-1];
      guard    = norm_hi ? acc_q[P-1] : acc_q[P-2];
      rnd      = round_nearest(sig_n, guard);
      sig_r    = rnd[P] ? rnd[P:1] : rnd[P-1:0];
      e_adj    = exp_sum_q + (norm_hi ? ONE_S : ZERO_S) + (rnd[P] ? ONE_S : ZERO_S);
      nan_res  = (cls_a_q == FP_NAN) || (cls_b_q == FP_NAN) ||
                 (cls_a_q == FP_ZERO && cls_b_q == FP_INF) ||
                 (cls_a_q == FP_INF && cls_b_q == FP_ZERO);
      inf_res  = (cls_a_q == FP_INF) || (cls_b_q == FP_INF);
      zero_res = (cls_a_q == FP_ZERO) || (cls_b_q == FP_ZERO);
      if (nan_res)
         result_d = {sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b1}}};
      else if (inf_res)
         result_d = {sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
      else if (zero_res)
         result_d = {sign_q, {(W-1){1'b0}}};
      else
         result_d = pack_result(sign_q, e_adj, sig_r);
   end

endmodule

// File: tb/tb_floating_point_multiplier_iter.sv
// Directed bench for the iterative FP multiplier (single precision).
module tb_floating_point_multiplier_iter;

   logic        clk_i = 1'b0;
   logic        rst_i, valid_i, ready_i, ready_o, valid_o;
   logic [31:0] fp_a_i, fp_b_i, fp_o;
   int          total = 0;
   int          bad   = 0;

`ifdef FP_MUL_ITER_EARLY_OUT_EN
   localparam int SPECIAL_LAT = 2;
`else
   localparam int SPECIAL_LAT = 26;
`endif

   always #5 clk_i = ~clk_i;

   floating_point_multiplier_iter #(.EXP_WIDTH(8), .FRAC_WIDTH(23)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .fp_a_i(fp_a_i), .fp_b_i(fp_b_i), .valid_i(valid_i),
      .ready_o(ready_o), .fp_o(fp_o), .valid_o(valid_o), .ready_i(ready_i)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // Issue one operation; returns when valid_o is seen (or the bound expires).
   // lat counts edges with the accept edge as the first.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] y, output int lat);
      check_eq("rdy_idle", {31'b0, ready_o}, 32'd1);
      fp_a_i  = a;
      fp_b_i  = b;
      valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      lat = 1;
      check_eq("rdy_drop", {31'b0, ready_o}, 32'd0);
      while (!valid_o && lat < 200) begin
         @(posedge clk_i); #1;
         lat++;
      end
      y = fp_o;
   endtask

   logic [31:0] va[10], vb[10], vy[10];
   bit          vs[10];
   logic [31:0] y;
   int          lat, nvalid;

   initial begin
      va = '{32'h3FC00000, 32'h3FC00000, 32'h3F800001, 32'hC0000000, 32'h7F000000,
             32'h00800000, 32'h00000000, 32'h80000000, 32'h7FC00000, 32'hFF800000};
      vb = '{32'h40000000, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 32'h40000000,
             32'h3F000000, 32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
      vy = '{32'h40400000, 32'h40100000, 32'h3FC00002, 32'hC0C00000, 32'h7F800000,
             32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFF800000};
      vs = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};

      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; fp_a_i = '0; fp_b_i = '0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      check_eq("rst_ready", {31'b0, ready_o}, 32'd1);
      check_eq("rst_valid", {31'b0, valid_o}, 32'd0);
      check_eq("rst_fp", fp_o, 32'h0);

      // Directed vectors, each released immediately (ready_i high).
      for (int i = 0; i < 10; i++) begin
         run_op(va[i], vb[i], y, lat);
         check_eq($sformatf("res%0d", i), y, vy[i]);
         check_eq($sformatf("lat%0d", i), 32'(lat), vs[i] ? 32'(SPECIAL_LAT) : 32'd26);
         @(posedge clk_i); #1;
         check_eq($sformatf("back%0d", i), {31'b0, ready_o}, 32'd1);
      end

      // Back-pressure: result held while ready_i is low, valid_i ignored.
      ready_i = 1'b0;
      run_op(32'h3FC00000, 32'h3FC00000, y, lat);
      check_eq("bp_res", y, 32'h40100000);
      fp_a_i  = 32'h40000000;
      fp_b_i  = 32'h40000000;
      valid_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk_i); #1;
         check_eq("bp_valid", {31'b0, valid_o}, 32'd1);
         check_eq("bp_fp", fp_o, 32'h40100000);
         check_eq("bp_ready", {31'b0, ready_o}, 32'd0);
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      check_eq("bp_idle_rdy", {31'b0, ready_o}, 32'd1);
      check_eq("bp_idle_vld", {31'b0, valid_o}, 32'd0);
      @(posedge clk_i); #1;
      check_eq("bp_no_accept", {31'b0, ready_o}, 32'd1);

      // Reset during MUL step 10 aborts the operation.
      fp_a_i  = 32'h3FC00000;
      fp_b_i  = 32'h40000000;
      valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      check_eq("abort_valid", {31'b0, valid_o}, 32'd0);
      check_eq("abort_ready", {31'b0, ready_o}, 32'd1);
      check_eq("abort_fp", fp_o, 32'h0);
      nvalid = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk_i); #1;
         if (valid_o) nvalid++;
      end
      check_eq("abort_no_out", 32'(nvalid), 32'd0);
      run_op(32'hC0000000, 32'h40400000, y, lat);
      check_eq("post_abort_res", y, 32'hC0C00000);
      check_eq("post_abort_lat", 32'(lat), 32'd26);
      @(posedge clk_i); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
